// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial-output bundle for piso_serializer
//   par_in/load_valid   : word offered by the producer
//   load_ready          : serializer accepts a word this cycle
//   data_out/bit_valid  : serial stream, MSB first
//   frame_done          : pulse on the last bit of each frame
//   busy                : serializer not idle
`timescale 1ns/1ps
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] par_in;
  logic load_valid;
  logic load_ready;
  logic data_out;
  logic bit_valid;
  logic frame_done;
  logic busy;
  modport master (output par_in, load_valid, input load_ready, data_out, bit_valid, frame_done, busy);
  modport slave (input par_in, load_valid, output load_ready, data_out, bit_valid, frame_done, busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial converter with back-to-back load handshake
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : piso_serializer_if slave (par_in, load_valid, load_ready, data_out,
//          bit_valid, frame_done, busy)
//   Define PISO_PARITY_EN to append an even-parity bit after the LSB of each frame.
`timescale 1ns/1ps
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rstn,
  piso_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, nstate;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic last, load;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nstate;
  // Outputs are decoded from registered state only, so reset forces them at once.
  always_comb begin
`ifdef PISO_PARITY_EN
    last = state == PARITY;
`else
    last = state == SHIFT && cnt == '0;
`endif
    bus.load_ready = state == IDLE || last;
    load = bus.load_valid && bus.load_ready;
    bus.bit_valid = state != IDLE;
    bus.busy = state != IDLE;
    bus.frame_done = last;
`ifdef PISO_PARITY_EN
    nstate = load ? SHIFT : state == SHIFT && cnt == '0 ? PARITY : state == SHIFT ? SHIFT : IDLE;
    bus.data_out = state == PARITY ? par : bus.bit_valid & sreg[WIDTH-1];
`else
    nstate = load ? SHIFT : state == SHIFT && cnt != '0 ? SHIFT : IDLE;
    bus.data_out = bus.bit_valid & sreg[WIDTH-1];
`endif
  end
  // Counter holds at zero on the last bit; only a new load reloads it.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sreg <= '0;
      cnt <= '0;
`ifdef PISO_PARITY_EN
      par <= 1'b0;
`endif
    end else if (load) begin
      sreg <= bus.par_in;
      cnt <= CMAX;
`ifdef PISO_PARITY_EN
      par <= ^bus.par_in;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      sreg <= sreg << 1;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed scoreboard bench for piso_serializer
`timescale 1ns/1ps
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  piso_serializer_if #(.WIDTH(W)) bus();
  piso_serializer #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int rem = 0;
  bit q[$];
  bit mon_en = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: rem = cycles left in the current frame; a word is taken
  // when idle or on the final frame cycle, and its bits join the expected stream.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      rem = 0;
      q.delete();
    end else if (bus.load_valid && rem <= 1) begin
      for (int i = W - 1; i >= 0; i--) q.push_back(bus.par_in[i]);
      if (FL > W) q.push_back(^bus.par_in);
      rem = FL;
    end else if (rem > 0) rem--;
  end
  // Monitor: pops one expected bit per DUT bit_valid cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en && rstn) begin
      chk("busy", bus.busy, rem > 0);
      chk("load_ready", bus.load_ready, rem <= 1);
      chk("frame_done", bus.frame_done, rem == 1);
      chk("bit_valid", bus.bit_valid, rem > 0);
      if (!bus.bit_valid) chk("data_out_idle", bus.data_out, 0);
      else if (q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("data_out", bus.data_out, q.pop_front());
    end
  end
  task automatic drive(input logic lv, input logic [W-1:0] d);
    @(negedge clk);
    bus.load_valid = lv;
    bus.par_in = d;
  endtask
  task automatic drain();
    repeat (FL + 2) drive(1'b0, '0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_load_ready"}, bus.load_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_bit_valid"}, bus.bit_valid, 0);
    chk({tag, "_data_out"}, bus.data_out, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.par_in = '0;
    #12;
    chk_reset("por");
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 8'hA5);
    drain();
    drive(1'b1, 8'hA5);
    repeat (FL) drive(1'b1, 8'h3C);
    drain();
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'h00);
    repeat (5) drive(1'b1, 8'h00);
    drain();
    drive(1'b1, 8'h07);
    drain();
    drive(1'b1, 8'hA5);
    repeat (4) drive(1'b0, 8'h00);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 8'h81);
    drain();
    repeat (400) drive($urandom_range(0, 3) != 0, W'($urandom));
    drain();
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port par_in, input, WIDTH, the parallel word to serialize.
REQ-005 The block SHALL have port load_valid, input, 1, meaning par_in holds a word offered for loading.
REQ-006 The block SHALL have port load_ready, output, 1, meaning the block accepts a word this cycle.
REQ-007 The block SHALL have port data_out, output, 1, the serial bit stream for the downstream pattern detector.
REQ-008 The block SHALL have port bit_valid, output, 1, meaning data_out carries a frame bit this cycle.
REQ-009 The block SHALL have port frame_done, output, 1, a one-cycle pulse on the last bit of each frame.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-012 A load SHALL occur on a rising edge where load_valid and load_ready are both high; par_in is captured into the shift register and the bit counter is set to WIDTH-1.
REQ-013 IDLE -> SHIFT on load; SHIFT stays while the bit counter is nonzero, decrementing by one per cycle.
REQ-014 Bits SHALL be emitted MSB first, one per cycle, starting the cycle after the load; latency from the load edge to the first bit is 1 cycle.
REQ-015 bit_valid SHALL be 1 in SHIFT and PARITY, 0 in IDLE; data_out SHALL be 0 whenever bit_valid is 0.
REQ-016 load_ready SHALL be 1 in IDLE and in the last bit cycle of a frame, and 0 otherwise.
REQ-017 On a load in the last bit cycle, the next cycle SHALL emit the MSB of the new word with no idle gap, and the FSM SHALL stay in SHIFT.
REQ-018 When the last bit cycle has no load, the FSM SHALL return to IDLE on the next edge.
REQ-019 frame_done SHALL be 1 only in the last bit cycle: bit counter 0 in SHIFT without parity, or the PARITY cycle with parity.
REQ-020 load_valid while load_ready is 0 SHALL be ignored; par_in changes while busy SHALL NOT affect the frame in flight.
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-022 While rstn is 0, the block SHALL immediately set state IDLE, shift register 0, counter 0, data_out 0, bit_valid 0, frame_done 0, busy 0 and load_ready 1 (load_ready does not depend on clk).
REQ-023 A reset mid-frame SHALL discard the remaining bits; the first edge after rstn rises SHALL be able to accept a new load.

Configuration
REQ-024 With macro PISO_PARITY_EN defined, after the LSB the FSM SHALL enter PARITY for one cycle and emit the even parity bit (the XOR of the captured word).
REQ-025 With PISO_PARITY_EN defined, load_ready and frame_done SHALL move from the LSB cycle to the PARITY cycle, and the frame is WIDTH+1 cycles.
REQ-026 Without PISO_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame is WIDTH cycles.

Verification (WIDTH=8, cycle 0 = load edge)
REQ-027 Load 8'hA5 from IDLE -> data_out 1,0,1,0,0,1,0,1 on cycles 1..8, bit_valid 1 on cycles 1..8, frame_done on cycle 8 only, busy 0 from cycle 9.
REQ-028 Load 8'hA5 with load_valid held and par_in=8'h3C on cycle 8 -> cycles 9..16 emit 0,0,1,1,1,1,0,0 with no gap and bit_valid continuously 1.
REQ-029 Load 8'hFF, then pulse load_valid with 8'h00 on cycles 2..6 -> the pulse is ignored and eight 1 bits are emitted.
REQ-030 Load 8'hA5, assert rstn=0 mid-cycle 4 -> all outputs 0 and load_ready 1 at once; after release, a load of 8'h81 emits 1,0,0,0,0,0,0,1.
REQ-031 With PISO_PARITY_EN: load 8'hA5 -> cycle 9 emits 0 with frame_done; load 8'h07 -> cycle 9 emits 1; load_ready 0 on cycle 8 and 1 on cycle 9.
